pkt_seq_ctrl: RTL and testbench

PKT_SEQ_CTRL -- requirements
Module: pkt_seq_ctrl

---
 rtl/pkt_seq_ctrl.sv | 119 +++++++++++
 tb/tb_pkt_seq_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_seq_ctrl.sv
// Packet sequencing controller: validates the flag word and sequence number of each
// accepted packet, then serializes passing packets one word at a time.
module pkt_seq_ctrl #(
    parameter int BUS_SIZE  = 16,
    parameter int WORD_SIZE = 4,
    parameter int WORD_NUM  = BUS_SIZE / WORD_SIZE,
    localparam int SEL_W    = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_SIZE-1:0]  bus_data_in,
    output logic [WORD_SIZE-1:0] word_out,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic [SEL_W-1:0]     word_sel,
    output logic                 word_last,
    output logic [2:0]           state,
    output logic                 error,
    output logic [7:0]           drop_count
);

    typedef enum logic [2:0] {
        RESET_STATE = 3'd0,
        FIRST_PKT   = 3'd1,
        REG_PKT     = 3'd2,
        F_ERROR     = 3'd3,
        SEQ_ERROR   = 3'd4
    } state_e;

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(WORD_NUM - 1);

    state_e                 state_q;
    logic [WORD_SIZE-1:0]   seq_q;
    logic [BUS_SIZE-1:0]    pkt_q;
    logic [SEL_W-1:0]       sel_q;
    logic                   word_valid_q;
    logic                   word_last_q;
    logic                   in_ready_q;
    logic                   error_q;
    logic [7:0]             drop_q;

    logic                   accept;
    logic                   flag_ok;
    logic                   seq_ok;
    logic                   pkt_pass;
    logic [WORD_SIZE-1:0]   in_seq;
    logic [WORD_SIZE-1:0]   seq_next;

    assign accept   = in_valid && in_ready_q;
    assign flag_ok  = &bus_data_in[WORD_SIZE-1:0];
    assign in_seq   = bus_data_in[(WORD_NUM-1)*WORD_SIZE +: WORD_SIZE];
    assign seq_next = seq_q + 1'b1;
    assign seq_ok   = (in_seq == seq_next);
    // Only REG_PKT checks continuity; the error states and FIRST_PKT re-seed on any good flag.
    assign pkt_pass = flag_ok && ((state_q != REG_PKT) || seq_ok);

    // NOTE: every register here is assigned with <= so all state updates see the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RESET_STATE;
            seq_q        <= '0;
            pkt_q        <= '0;
            sel_q        <= '0;
            word_valid_q <= 1'b0;
            word_last_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            error_q      <= 1'b0;
            drop_q       <= '0;
        end else begin
            case (state_q)
                RESET_STATE: begin
                    state_q    <= FIRST_PKT;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    if (accept) begin
                        if (pkt_pass) begin
                            state_q      <= REG_PKT;
                            error_q      <= 1'b0;
                            seq_q        <= in_seq;
                            pkt_q        <= bus_data_in;
                            sel_q        <= '0;
                            word_valid_q <= 1'b1;
                            word_last_q  <= (WORD_NUM == 1);
                            in_ready_q   <= 1'b0;
                        end else begin
                            state_q <= flag_ok ? SEQ_ERROR : F_ERROR;
                            error_q <= 1'b1;
                            if (drop_q != 8'hFF) begin
                                drop_q <= drop_q + 8'd1;
                            end
                        end
                    end else if (word_valid_q && word_ready) begin
                        if (word_last_q) begin
                            word_valid_q <= 1'b0;
                            word_last_q  <= 1'b0;
                            in_ready_q   <= 1'b1;
                        end else begin
                            sel_q       <= sel_q + 1'b1;
                            word_last_q <= ((sel_q + 1'b1) == LAST_SEL);
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign word_out   = pkt_q[sel_q*WORD_SIZE +: WORD_SIZE];
    assign word_valid = word_valid_q;
    assign word_sel   = sel_q;
    assign word_last  = word_last_q;
    assign state      = state_q;
    assign error      = error_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_pkt_seq_ctrl.sv
// Scoreboard bench for pkt_seq_ctrl: a packet model predicts state, drops and the word
// stream; expected words are queued on acceptance and popped as the DUT emits them.
module tb_pkt_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] bus_data_in = '0;
    logic [3:0]  word_out;
    logic        word_valid;
    logic        word_ready = 1'b1;
    logic [1:0]  word_sel;
    logic        word_last;
    logic [2:0]  state;
    logic        error;
    logic [7:0]  drop_count;

    pkt_seq_ctrl #(.BUS_SIZE(16), .WORD_SIZE(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .bus_data_in(bus_data_in),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_sel   (word_sel),
        .word_last  (word_last),
        .state      (state),
        .error      (error),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] word;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         total = 0;
    int         bad = 0;
    int         m_state = 0;
    logic [3:0] m_seq = '0;
    int         m_drop = 0;
    bit         rnd_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Word monitor: sampled just after the falling edge, where word_ready is already settled.
    always begin
        @(negedge clk);
        #1;
        if (!reset && word_valid && word_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_word", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("word_out", word_out, mon_e.word);
                check("word_sel", word_sel, mon_e.sel);
                check("word_last", word_last, mon_e.sel == 2'd3);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rnd_ready) word_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset(input bit check_vals);
        @(negedge clk);
        reset      = 1'b1;
        in_valid   = 1'b0;
        word_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (check_vals) begin
            check("rst_state", state, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_word_valid", word_valid, 0);
            check("rst_word_sel", word_sel, 0);
            check("rst_word_last", word_last, 0);
            check("rst_word_out", word_out, 0);
            check("rst_error", error, 0);
            check("rst_drop", drop_count, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        m_state = 1;
        m_seq   = '0;
        m_drop  = 0;
        @(posedge clk);
        #1;
        check("post_rst_state", state, 1);
        check("post_rst_in_ready", in_ready, 1);
    endtask

    task automatic send(input logic [15:0] pkt);
        int         n = 0;
        bit         flag_ok;
        bit         pass;
        logic [3:0] s;
        logic [3:0] nxt;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'd0, 32'd1);
            return;
        end
        in_valid    = 1'b1;
        bus_data_in = pkt;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        bus_data_in = 16'($urandom());
        flag_ok = (pkt[3:0] == 4'hF);
        s       = pkt[15:12];
        nxt     = m_seq + 4'd1;
        pass    = flag_ok && (m_state != 2 || s == nxt);
        if (pass) begin
            m_state = 2;
            m_seq   = s;
            for (int k = 0; k < 4; k++) sb.push_back({2'(k), pkt[k*4 +: 4]});
        end else begin
            m_state = flag_ok ? 4 : 3;
            if (m_drop < 255) m_drop++;
        end
        check("state", state, m_state);
        check("error", error, (m_state == 3 || m_state == 4));
        check("drop_count", drop_count, m_drop);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || word_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain_queue", sb.size(), 0);
        check("drain_idle", word_valid, 0);
        check("drain_in_ready", in_ready, 1);
    endtask

    initial begin
        int n;
        apply_reset(1'b1);

        // Basic in-order stream.
        send(16'h000F);
        send(16'h100F);
        send(16'h200F);
        drain();

        // Sequence wrap from F to 0.
        apply_reset(1'b0);
        send(16'hF00F);
        send(16'h000F);
        drain();

        // Bad flag, then recovery.
        apply_reset(1'b0);
        send(16'h000F);
        send(16'h100E);
        send(16'h500F);
        drain();

        // Sequence gap, then recovery.
        apply_reset(1'b0);
        send(16'h000F);
        send(16'h200F);
        send(16'h300F);
        drain();

        // Downstream stall during word 1.
        send(16'h4A5F);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(word_valid && word_sel == 2'd1) && n < 50);
        word_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_word_out", word_out, 4'h5);
            check("stall_word_sel", word_sel, 1);
            check("stall_word_valid", word_valid, 1);
            check("stall_in_ready", in_ready, 0);
        end
        @(negedge clk);
        word_ready = 1'b1;
        drain();

        // Reset in the middle of serialization.
        send(16'h5BCF);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(word_valid && word_sel == 2'd2) && n < 50);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_word_valid", word_valid, 0);
        check("midrst_state", state, 0);
        check("midrst_drop", drop_count, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_word_sel", word_sel, 0);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        m_state = 1;
        m_seq   = '0;
        m_drop  = 0;

        // Mixed traffic with random downstream back-pressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            logic [3:0] sq;
            logic [3:0] fl;
            sq = 4'(i);
            if (i == 9) sq = 4'(i + 2);
            fl = (i % 5 == 3) ? 4'h7 : 4'hF;
            send({sq, 8'($urandom()), fl});
        end
        rnd_ready  = 1'b0;
        word_ready = 1'b1;
        drain();
        check("final_drop", drop_count, m_drop);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
